// File: rtl/mux_rr_arbiter_if.sv
// Purpose : request/data/grant bundle between N requesters and the shared-mux arbiter.
// Latency : none (wires only).
// Backpr. : req is held by a requester until it is done with the output; gnt/busy report ownership.
//
// Signals:
//   req  [N-1:0]    level request per requester
//   din  [N*W-1:0]  flattened requester data, requester i at din[i*W +: W]
//   gnt  [N-1:0]    one-hot grant, zero when idle
//   sel  [SELW-1:0] index of the current owner, zero when idle
//   y    [W-1:0]    muxed data of the owner, zero when idle
//   busy            high while a grant is active
// Modports: master = requester side, slave = arbiter side.
interface mux_rr_arbiter_if #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
);
    logic [N-1:0]    req;
    logic [N*W-1:0]  din;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] sel;
    logic [W-1:0]    y;
    logic            busy;

    modport master (output req, din, input gnt, sel, y, busy);
    modport slave  (input req, din, output gnt, sel, y, busy);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Purpose : round-robin arbiter owning one cascaded 2:1-mux N:1 data path shared by N requesters.
// Latency : 1 cycle req -> gnt/sel/busy; y is combinational from sel/din.
// Backpr. : owner keeps the grant while its req stays high; release hands over at the same edge.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mux_rr_arbiter_if.slave (req, din in; gnt, sel, y, busy out)
//
// Optional build macro: MUX_RR_ARBITER_HOLD_TIMEOUT_EN
//   defined   -> an owner is forced to rotate after MAX_HOLD cycles when others are waiting
//   undefined -> ownership is held indefinitely, MAX_HOLD only range-checked
module mux_rr_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int SELW     = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    mux_rr_arbiter_if.slave bus
);

    // Elaboration-time parameter checks
    if (SELW != $clog2(N)) begin : g_selw_chk
        $error("mux_rr_arbiter: SELW must equal clog2(N)");
    end
    if (N < 2 || N > 8) begin : g_n_chk
        $error("mux_rr_arbiter: N must be in 2..8");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_hold_chk
        $error("mux_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t          state_q, state_nxt;
    logic [N-1:0]    gnt_q, gnt_nxt;
    logic [SELW-1:0] sel_q, sel_nxt;
    logic [SELW-1:0] ptr_q, ptr_nxt;

    logic            found;
    logic [SELW-1:0] win;
    logic            grant;
    logic            owner_req;
    logic            others;
    logic            timeout;
    logic            busy;
    logic [W-1:0]    y_mux;

    assign owner_req = bus.req[sel_q];
    // Outside OWN gnt_q is zero, so this is simply "any request".
    assign others    = |(bus.req & ~gnt_q);

    // Round-robin scan: start at ptr, ascending, wrap N-1 -> 0, first set bit wins.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr_q) + off) % N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = SELW'(idx);
            end
        end
    end

`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_nxt;

    // ptr already points past the owner, so a forced re-scan picks someone else
    // whenever another request is pending.
    assign timeout = (state_q == OWN) && (hold_q == HOLD_LAST) && others;

    always_comb begin
        hold_nxt = hold_q;
        if (grant || state_nxt == IDLE) begin
            hold_nxt = '0;
        end else if (state_q == OWN && hold_q != HOLD_LAST) begin
            hold_nxt = hold_q + 8'd1;  // saturates at MAX_HOLD-1
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_nxt;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_nxt;
            gnt_q   <= gnt_nxt;
            sel_q   <= sel_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        gnt_nxt   = gnt_q;
        sel_nxt   = sel_q;
        ptr_nxt   = ptr_q;
        grant     = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant = 1'b1;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    // Owner's bit is low, so any winner is another requester:
                    // hand over at this same edge with no dead cycle.
                    if (found) begin
                        grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        sel_nxt   = '0;
                    end
                end else if (timeout) begin
                    grant = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                sel_nxt   = '0;
            end
        endcase

        if (grant) begin
            state_nxt    = OWN;
            sel_nxt      = win;
            gnt_nxt      = '0;
            gnt_nxt[win] = 1'b1;
            // Winner drops to lowest priority for the next arbitration.
            ptr_nxt      = (int'(win) == N - 1) ? '0 : win + 1'b1;
        end
    end

    // Output logic: cascade of 2:1 muxes steered by sel, gated by busy.
    always_comb begin
        busy  = (state_q == OWN);
        y_mux = bus.din[0 +: W];
        for (int i = 1; i < N; i++) begin
            if (int'(sel_q) == i) begin
                y_mux = bus.din[i*W +: W];
            end
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy;
    assign bus.y    = busy ? y_mux : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Purpose : directed self-checking bench for mux_rr_arbiter.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpr. : not applicable (bench).
module tb_mux_rr_arbiter;

`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
    localparam int TB_MAX_HOLD = 4;
`else
    localparam int TB_MAX_HOLD = 16;
`endif

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    logic [7:0] dbyte [4] = '{8'hA5, 8'hB2, 8'hC3, 8'hD4};

    mux_rr_arbiter_if #(.N(4), .W(8), .SELW(2)) bus ();

    mux_rr_arbiter #(
        .N(4), .W(8), .SELW(2), .MAX_HOLD(TB_MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Continuous invariant: gnt is exactly the one-hot of sel when busy, else zero.
    always @(negedge clk) begin
        compared++;
        if (bus.gnt !== (bus.busy ? (4'b0001 << bus.sel) : 4'b0000)) begin
            mismatched++;
            $display("FAIL invariant_gnt_sel_busy: got gnt=%b sel=%0d busy=%b", bus.gnt, bus.sel, bus.busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 4'b0000;
        step();
        rst     = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = 4'b0000;
        bus.din = {dbyte[3], dbyte[2], dbyte[1], dbyte[0]};
        step();
        step();
        compared++;
        if ({bus.gnt, bus.sel, bus.busy, bus.y} !== 15'd0) begin
            mismatched++;
            $display("FAIL reset_state: got gnt=%b sel=%0d busy=%b y=%h, expected all zero",
                     bus.gnt, bus.sel, bus.busy, bus.y);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bus.req = 4'b0001;
        step();
        compared++;
        if ({bus.gnt, bus.sel, bus.busy, bus.y} !== {4'b0001, 2'd0, 1'b1, 8'hA5}) begin
            mismatched++;
            $display("FAIL basic_grant: got gnt=%b sel=%0d busy=%b y=%h, expected 0001/0/1/a5",
                     bus.gnt, bus.sel, bus.busy, bus.y);
        end
        bus.req = 4'b0000;
        step();
        compared++;
        if ({bus.gnt, bus.sel, bus.busy, bus.y} !== 15'd0) begin
            mismatched++;
            $display("FAIL basic_release: got gnt=%b sel=%0d busy=%b y=%h, expected all zero",
                     bus.gnt, bus.sel, bus.busy, bus.y);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rq  [5] = '{4'b1010, 4'b1010, 4'b1000, 4'b0010, 4'b0000};
        logic [3:0] eg  [5] = '{4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0000};
        logic [1:0] es  [5] = '{2'd1, 2'd1, 2'd3, 2'd1, 2'd0};
        logic [7:0] ey  [5] = '{8'hB2, 8'hB2, 8'hD4, 8'hB2, 8'h00};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.req = rq[i];
            step();
            compared++;
            if ({bus.gnt, bus.sel, bus.busy, bus.y} !== {eg[i], es[i], |eg[i], ey[i]}) begin
                mismatched++;
                $display("FAIL back_to_back[%0d]: got gnt=%b sel=%0d busy=%b y=%h, expected gnt=%b sel=%0d y=%h",
                         i, bus.gnt, bus.sel, bus.busy, bus.y, eg[i], es[i], ey[i]);
            end
        end
    endtask

    task automatic test_fairness();
        int seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] eg;
        do_reset();
        bus.req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            eg = 4'b0001 << seq[i];
            for (int h = 0; h < 2; h++) begin
                compared++;
                if ({bus.gnt, bus.sel, bus.busy, bus.y} !== {eg, 2'(seq[i]), 1'b1, dbyte[seq[i]]}) begin
                    mismatched++;
                    $display("FAIL fairness[%0d.%0d]: got gnt=%b sel=%0d y=%h, expected gnt=%b sel=%0d y=%h",
                             i, h, bus.gnt, bus.sel, bus.y, eg, seq[i], dbyte[seq[i]]);
                end
                if (h == 0) step();
            end
            bus.req = 4'b1111 & ~eg;
            step();
            bus.req = 4'b1111;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b0001;
        step();
        compared++;
        if (bus.gnt !== 4'b0001) begin
            mismatched++;
            $display("FAIL async_pre_own: got gnt=%b, expected 0001", bus.gnt);
        end
        #3;
        rst = 1'b1;
        #1;
        compared++;
        if ({bus.gnt, bus.sel, bus.busy, bus.y} !== 15'd0) begin
            mismatched++;
            $display("FAIL async_reset_immediate: got gnt=%b sel=%0d busy=%b y=%h, expected all zero",
                     bus.gnt, bus.sel, bus.busy, bus.y);
        end
        bus.req = 4'b0100;
        step();
        compared++;
        if ({bus.gnt, bus.busy} !== 5'd0) begin
            mismatched++;
            $display("FAIL async_reset_held: got gnt=%b busy=%b, expected 0000/0", bus.gnt, bus.busy);
        end
        rst = 1'b0;
        step();
        compared++;
        if ({bus.gnt, bus.sel, bus.busy, bus.y} !== {4'b0100, 2'd2, 1'b1, 8'hC3}) begin
            mismatched++;
            $display("FAIL async_reset_regrant: got gnt=%b sel=%0d busy=%b y=%h, expected 0100/2/1/c3",
                     bus.gnt, bus.sel, bus.busy, bus.y);
        end
    endtask

`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
    task automatic test_hold_timeout();
        logic [3:0] eg;
        do_reset();
        bus.req = 4'b0011;
        for (int c = 0; c < 16; c++) begin
            step();
            eg = ((c / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
            compared++;
            if (bus.gnt !== eg) begin
                mismatched++;
                $display("FAIL hold_timeout_rotate[%0d]: got gnt=%b, expected %b", c, bus.gnt, eg);
            end
        end
        bus.req = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            step();
            compared++;
            if (bus.gnt !== 4'b0001) begin
                mismatched++;
                $display("FAIL hold_timeout_sole[%0d]: got gnt=%b, expected 0001", c, bus.gnt);
            end
        end
    endtask
`else
    task automatic test_hold_forever();
        do_reset();
        bus.req = 4'b0011;
        for (int c = 0; c < 100; c++) begin
            step();
            compared++;
            if (bus.gnt !== 4'b0001) begin
                mismatched++;
                $display("FAIL hold_forever[%0d]: got gnt=%b, expected 0001", c, bus.gnt);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_fairness();
        test_async_reset();
`ifdef MUX_RR_ARBITER_HOLD_TIMEOUT_EN
        test_hold_timeout();
`else
        test_hold_forever();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one N:1 data mux (the gate-level 2:1 mux cell cascaded) between N requesters.
- Decides which requester owns the shared output and holds the grant until the owner releases it.
- Drives the mux select, the one-hot grant and the muxed output.
- Sits between requesting datapath blocks and any single shared downstream consumer.

Parameters:
- N, 4, number of requesters; legal range 2..8.
- W, 8, data width per requester.
- SELW, 2, select width; must equal ceil(log2(N)); checked at elaboration.
- MAX_HOLD, 16, maximum consecutive grant cycles before forced rotation. Used only with HOLD_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request per requester; level-held while ownership is wanted.
- din  input  N*W  flattened requester data; requester i occupies din[i*W +: W].
- gnt  output  N  registered one-hot grant; all-zero when idle.
- sel  output  SELW  registered index of current owner; 0 when idle.
- y  output  W  muxed data, combinational from sel/din; 0 when busy=0.
- busy  output  1  registered; 1 while any grant is active.

Behaviour:
- Reset (async, rst=1): gnt=0, sel=0, busy=0, round-robin pointer ptr=0, state IDLE, hold counter=0. y=0 follows immediately. Reset mid-grant drops ownership without waiting for a clock.
- States: IDLE (no owner), OWN (one owner).
- Arbitration function:
  - Scan req starting at index ptr, ascending, wrapping N-1 -> 0.
  - The first set bit wins.
  - On granting winner k, ptr <= (k+1) mod N, so the winner becomes lowest priority.
- IDLE:
  - At each edge where req != 0, the winner is granted.
  - Latency is 1 cycle: req seen at edge t gives gnt/sel/busy valid after edge t.
  - State -> OWN.
- OWN:
  - Grant holds while req[sel]=1; ptr is unchanged while holding.
  - At the edge where req[sel]=0 is sampled:
    - If any other req is set, re-arbitrate at the same edge. This gives a back-to-back handover with no dead cycle.
    - Otherwise, gnt=0, busy=0, sel=0, state -> IDLE.
- Release-and-rerequest: the owner's req must be low at a sampling edge to release. A one-cycle low pulse counts as a release.
- Simultaneous requests: resolved purely by ptr, never by index order, except in the first arbitration after reset (ptr=0).
- y equals din[sel*W +: W] when busy=1, else all zeros. There is no register on y; the path is mux only.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[sel]=busy.
  - The owner never changes unless a release or a timeout occurs.

Optional Feature:
- Macro: MUX_RR_ARBITER_HOLD_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each cycle in OWN.
  - When the counter reaches MAX_HOLD-1 and any other req bit is set, the next edge forcibly re-arbitrates. The owner competes at lowest priority because ptr has already moved past it.
  - If no other requester is pending, the owner keeps the grant and the counter saturates at MAX_HOLD-1.
- Undefined: no counter is built, ownership is held indefinitely, and MAX_HOLD is ignored.

Test Plan:
1. Reset then req=4'b0001, din[0]=8'hA5 -> next edge: gnt=0001, sel=0, busy=1, y=A5. Drop req -> next edge: gnt=0, busy=0, y=00.
2. From reset, req=4'b1010 held -> gnt=0010 (sel=1). Drop req[1] -> same edge gnt=1000 (sel=3), no idle cycle. Raise req[1] again and drop req[3] -> gnt=0010.
3. Fairness: req=4'b1111 held, each owner releasing for 1 cycle after 2 cycles of ownership -> grant order 0,1,2,3,0.
4. Async reset: assert rst mid-OWN between clock edges -> gnt=0, busy=0, y=0 immediately. Deassert with req=4'b0100 -> gnt=0100 one edge later.
5. With the macro defined, MAX_HOLD=4: req=4'b0011 held continuously -> ownership alternates 0,1,0,1 every 4 cycles. With only req[0] held -> gnt=0001 is never dropped.
6. Without the macro: same stimulus as scenario 5 -> gnt stays 0001 for 100 cycles.
